// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: sequences IF/ID/EXE/MEM/WB and decodes datapath enables/selects.
// Optional macro ILLEGAL_OP_TRAP_EN: unknown opcodes hold in ID and raise illegal_op.
module multicycle_control #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           ExtSel,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic           DBDataSrc,
    output logic [1:0]     PCSrc,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic           illegal_op,
`endif
    output logic [STW-1:0] state
);

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    typedef enum logic [STW-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t cur;

    logic is_rtype, is_alu, is_lw, is_sw, is_beq, is_j, is_jr, is_jal, is_halt, is_jump, known;

    always_comb begin
        is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_OR) ||
                   (opcode == OP_AND) || (opcode == OP_SLL) || (opcode == OP_SLT);
        is_alu   = is_rtype || (opcode == OP_ADDI) || (opcode == OP_ORI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_jr    = (opcode == OP_JR);
        is_jal   = (opcode == OP_JAL);
        is_halt  = (opcode == OP_HALT);
        is_jump  = is_j || is_jr || is_jal;
        known    = is_alu || is_lw || is_sw || is_beq || is_jump || is_halt;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cur <= S_IF;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (cur)
                S_IF:     cur <= S_ID;
                S_ID: begin
                    if (is_jump)              cur <= S_IF;
                    else if (is_halt)         cur <= S_ID;
                    else if (is_beq)          cur <= S_EXE_BR;
                    else if (is_lw || is_sw)  cur <= S_EXE_LS;
                    else if (is_alu)          cur <= S_EXE_AL;
                    else begin
`ifdef ILLEGAL_OP_TRAP_EN
                        cur       <= S_ID;
                        illegal_q <= 1'b1;
`else
                        cur <= S_IF;
`endif
                    end
                end
                S_EXE_AL: cur <= S_WB_AL;
                S_WB_AL:  cur <= S_IF;
                S_EXE_BR: cur <= S_IF;
                S_EXE_LS: cur <= S_MEM;
                S_MEM:    cur <= is_lw ? S_WB_LD : S_IF;
                S_WB_LD:  cur <= S_IF;
                default:  cur <= S_IF;
            endcase
        end
    end

    assign state = cur;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op = !Reset && (illegal_q || (cur == S_ID && !known));
`endif

    // Decode is combinational on the registered state: the opcode only becomes valid
    // after the IF edge, so ID-stage jump/jal controls cannot be precomputed a cycle early.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = '0;
        RegDst    = '0;
        WrRegDSrc = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = '0;
        if (!Reset) begin
            if (cur == S_IF) begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
            end else begin
                ExtSel    = (opcode != OP_ORI);
                ALUSrcA   = (opcode == OP_SLL);
                ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) || is_lw || is_sw;
                WrRegDSrc = !is_jal;
                DBDataSrc = is_lw;
                if (is_jal)                                          RegDst = 2'b00;
                else if (is_rtype)                                   RegDst = 2'b10;
                else if ((opcode == OP_ADDI) || (opcode == OP_ORI) || is_lw) RegDst = 2'b01;
                case (opcode)
                    OP_SUB, OP_BEQ: ALUOp = 3'b001;
                    OP_SLL:         ALUOp = 3'b010;
                    OP_OR, OP_ORI:  ALUOp = 3'b011;
                    OP_AND:         ALUOp = 3'b100;
                    OP_SLT:         ALUOp = 3'b110;
                    default:        ALUOp = 3'b000;
                endcase
            end
            case (cur)
                S_ID: begin
`ifdef ILLEGAL_OP_TRAP_EN
                    PCWre = is_jump;
`else
                    PCWre = is_jump || !known;
`endif
                    RegWre = is_jal;
                    if (is_j || is_jal) PCSrc = 2'b11;
                    else if (is_jr)     PCSrc = 2'b10;
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    if (is_beq && zero) PCSrc = 2'b01;
                end
                S_MEM: begin
                    PCWre = is_sw;
                    mRD   = is_lw;
                    mWR   = is_sw;
                end
                S_WB_AL, S_WB_LD: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed reset/halt cases plus random instruction stream.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] RegDst;
    logic       WrRegDSrc, RegWre, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc;
    logic [2:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    multicycle_control #(.OPW(6), .STW(3)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .PCSrc(PCSrc),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state(state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_JMP = 4, C_HALT = 5, C_UNK = 6;

    logic [5:0] ops [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                             6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                             6'b110100, 6'b111000, 6'b111001, 6'b111010, 6'b111111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b010000,
            6'b010001, 6'b010010, 6'b011000, 6'b100110: return C_ALU;
            6'b110001: return C_LW;
            6'b110000: return C_SW;
            6'b110100: return C_BEQ;
            6'b111000, 6'b111001, 6'b111010: return C_JMP;
            6'b111111: return C_HALT;
            default:   return C_UNK;
        endcase
    endfunction

    // Clocks per instruction class.
    function automatic int lat(input int c);
        case (c)
            C_ALU:   return 4;
            C_LW:    return 5;
            C_SW:    return 4;
            C_BEQ:   return 3;
            default: return 2;
        endcase
    endfunction

    // Stage visited on cycle k of an instruction of class c.
    function automatic int stage(input int c, input int k);
        int alu_s [4] = '{0, 1, 6, 7};
        int ls_s  [5] = '{0, 1, 2, 3, 4};
        int br_s  [3] = '{0, 1, 5};
        if (k < 2) return k;
        case (c)
            C_ALU:       return alu_s[k];
            C_LW, C_SW:  return ls_s[k];
            C_BEQ:       return br_s[k];
            default:     return 1;
        endcase
    endfunction

    function automatic int exp_aluop(input logic [5:0] op);
        case (op)
            6'b000001, 6'b110100: return 1;
            6'b011000:            return 2;
            6'b010000, 6'b010010: return 3;
            6'b010001:            return 4;
            6'b100110:            return 6;
            default:              return 0;
        endcase
    endfunction

    function automatic int exp_regdst(input logic [5:0] op);
        case (op)
            6'b111010:                       return 0;
            6'b000010, 6'b010010, 6'b110001: return 1;
            default:                         return 2;
        endcase
    endfunction

    task automatic check_cycle(input logic [5:0] op, input logic z, input int k);
        int    c    = cls(op);
        int    n    = lat(c);
        bit    last = (k == n - 1);
        bit    wr   = ((c == C_ALU || c == C_LW) && last) || (op == 6'b111010 && k == 1);
        int    pcs  = 0;
        string p    = $sformatf("op%b z%0d k%0d", op, z, k);
        if (last) begin
            if (op == 6'b111000 || op == 6'b111010) pcs = 3;
            else if (op == 6'b111001)               pcs = 2;
            else if (c == C_BEQ)                    pcs = z ? 1 : 0;
        end
        chk({p, " state"},    32'(state),    32'(stage(c, k)));
        chk({p, " fetch"},    {30'd0, InsMemRW, IRWre}, (k == 0) ? 32'd3 : 32'd0);
        chk({p, " PCWre"},    32'(PCWre),    32'(last));
        chk({p, " RegWre"},   32'(RegWre),   32'(wr));
        chk({p, " mem"},      {30'd0, mRD, mWR},
            32'({(c == C_LW && k == 3), (c == C_SW && k == 3)}));
        chk({p, " PCSrc"},    32'(PCSrc),    32'(pcs));
        if (wr) begin
            chk({p, " RegDst"},    32'(RegDst),    32'(exp_regdst(op)));
            chk({p, " WrRegDSrc"}, 32'(WrRegDSrc), 32'(op != 6'b111010));
            chk({p, " DBDataSrc"}, 32'(DBDataSrc), 32'(c == C_LW));
        end
        if (k >= 2) begin
            chk({p, " ALUOp"},   32'(ALUOp),   32'(exp_aluop(op)));
            chk({p, " ALUSrcA"}, 32'(ALUSrcA), 32'(op == 6'b011000));
            chk({p, " ALUSrcB"}, 32'(ALUSrcB),
                32'(op == 6'b000010 || op == 6'b010010 || c == C_LW || c == C_SW));
            chk({p, " ExtSel"},  32'(ExtSel),  32'(op != 6'b010010));
        end
    endtask

    // Entered with the FSM in IF between clock edges; returns the same way.
    task automatic run_instr(input logic [5:0] op, input logic z);
        opcode = op;
        zero   = z;
        for (int k = 0; k < lat(cls(op)); k++) begin
            check_cycle(op, z, k);
            @(posedge CLK); #1;
        end
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, " state"}, 32'(state), 32'd0);
        chk({tag, " outputs"},
            {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegDst,
             WrRegDSrc, RegWre, mRD, mWR, DBDataSrc, PCSrc}, 32'd0);
    endtask

    initial begin
        logic [5:0] op;
        Reset  = 1'b1;
        opcode = '0;
        zero   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_zero("por");
        Reset = 1'b0;
        #1;
        chk("por release state", 32'(state), 32'd0);
        chk("por release fetch", {30'd0, InsMemRW, IRWre}, 32'd3);

        run_instr(6'b000000, 1'b0);

        // Abort an add in EXE_AL.
        opcode = 6'b000000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("abort pre state", 32'(state), 32'd6);
        chk("abort pre RegWre", 32'(RegWre), 32'd0);
        Reset = 1'b1;
        #1;
        check_reset_zero("abort async");
        @(posedge CLK); #1;
        check_reset_zero("abort held");
        Reset = 1'b0;
        #1;
        chk("abort release state", 32'(state), 32'd0);
        chk("abort release fetch", {30'd0, InsMemRW, IRWre}, 32'd3);

        run_instr(6'b110001, 1'b0);
        run_instr(6'b110100, 1'b1);
        run_instr(6'b110100, 1'b0);
        run_instr(6'b111010, 1'b0);
        run_instr(6'b110000, 1'b1);
        run_instr(6'b111001, 1'b0);

        // halt: stays in ID with the PC frozen.
        opcode = 6'b111111;
        @(posedge CLK); #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("halt %0d state", i), 32'(state), 32'd1);
            chk($sformatf("halt %0d PCWre", i), 32'(PCWre), 32'd0);
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        #1;

`ifdef ILLEGAL_OP_TRAP_EN
        opcode = 6'b101010;
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("trap %0d state", i), 32'(state), 32'd1);
            chk($sformatf("trap %0d illegal_op", i), 32'(illegal_op), 32'd1);
            chk($sformatf("trap %0d PCWre", i), 32'(PCWre), 32'd0);
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        #1;
        chk("trap cleared", 32'(illegal_op), 32'd0);
        Reset = 1'b0;
        #1;
`else
        run_instr(6'b101010, 1'b0);
`endif

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(13, 0)];
`ifndef ILLEGAL_OP_TRAP_EN
            if ($urandom_range(7, 0) == 0) begin
                do op = 6'($urandom_range(63, 0)); while (cls(op) != C_UNK);
            end
`endif
            run_instr(op, 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control-unit FSM for the multicycle CPU. It sequences every instruction through the IF/ID/EXE/MEM/WB stages.
- It generates all write enables and mux selects for the datapath registers: PC, IR, ADR/BDR operand latches, ALUout and DBDR.
- It sits directly upstream of the operand latches. It decides which source reaches their inputs each clock and when the following stage consumes what they hold.

Parameters:
- OPW, 6, opcode width taken from IR[31:26].
- STW, 3, state-encoding width.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- opcode  input  OPW  IR[31:26]; stable from end of IF until next IF.
- zero  input  1  ALU zero flag.
- PCWre  output  1  PC write enable.
- IRWre  output  1  IR write enable.
- InsMemRW  output  1  instruction-memory read enable.
- ExtSel  output  1  1 = sign-extend immediate, 0 = zero-extend.
- ALUSrcA  output  1  1 = shamt, 0 = ADR.
- ALUSrcB  output  1  1 = extended immediate, 0 = BDR.
- ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt.
- RegDst  output  2  00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  output  1  1 = DBDR/ALUout, 0 = PC+4 (jal).
- RegWre  output  1  register-file write enable.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- DBDataSrc  output  1  1 = memory data, 0 = ALU result.
- PCSrc  output  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- state  output  STW  current state, for debug.

Behaviour:
- State encoding:
  - IF=000, ID=001.
  - EXE_AL=110, EXE_BR=101, EXE_LS=010.
  - MEM=011.
  - WB_AL=111, WB_LD=100.
- Opcodes handled:
  - R/ALU group: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110.
  - Memory: sw 110000, lw 110001.
  - Control flow: beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- State transitions:
  - IF -> ID always.
  - From ID:
    - j/jr/jal -> IF.
    - halt -> ID (hold).
    - beq -> EXE_BR.
    - sw/lw -> EXE_LS.
    - else -> EXE_AL.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for lw, IF for sw.
  - WB_LD -> IF.
- Instruction latency in clocks:
  - j/jr/jal 2, beq 3.
  - ALU and sw 4, lw 5.
  - halt: never leaves ID; PCWre stays 0.
- Output decode is Moore on state, qualified by opcode; PCSrc in EXE_BR also uses zero.
  - IF: InsMemRW=1, IRWre=1; all other enables 0.
  - PCWre=1 only in the final state of each instruction (WB_AL, WB_LD, EXE_BR, MEM for sw, ID for jumps), so the PC updates exactly once per instruction.
  - PCSrc: beq in EXE_BR = 01 if zero else 00; j/jal = 11; jr = 10; all other cases 00.
  - RegWre:
    - 1 only in WB_AL and WB_LD, and in ID for jal (RegDst=00, WrRegDSrc=0).
    - RegDst=10 for R-type, 01 for addi/ori/lw.
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw. Never both.
  - ExtSel=0 for ori, 1 otherwise.
  - ALUSrcB=1 for addi/ori/lw/sw; ALUSrcA=1 for sll.
  - ALUOp: beq uses sub; lw/sw use add.
- Outputs are held constant within a state; no output glitches on opcode are allowed outside IF.
- Reset:
  - Reset high at any time, including mid-instruction, forces state=IF immediately.
  - While Reset is high, PCWre, IRWre, RegWre, mRD, mWR and InsMemRW are forced to 0; all other outputs are 0.
  - On the first posedge after deassertion the FSM is in IF with fetch enables active. An aborted instruction leaves no partial write.
- Unknown opcode in ID: behaviour depends on ILLEGAL_OP_TRAP_EN (see Optional Feature).

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown opcode in ID holds the FSM in ID, identical to halt.
  - Adds output illegal_op (1 bit), asserted while held; it clears only on Reset.
- Undefined:
  - An unknown opcode is a nop: ID -> IF with PCWre=1 in ID and PCSrc=00.
  - No illegal_op port exists.

Test Plan:
- Reset mid-EXE_AL of add, deassert -> state=000 within same cycle; RegWre never pulses; next cycle InsMemRW=1, IRWre=1.
- add, opcode 000000 -> states 000,001,110,111,000.
  - ALUOp=000.
  - RegWre=1 and PCWre=1 only in WB_AL.
  - RegDst=10.
- lw, opcode 110001 -> 5-cycle sequence 000,001,010,011,100.
  - mRD=1 only in MEM.
  - DBDataSrc=1 and RegWre=1 in WB_LD.
  - RegDst=01.
- beq, opcode 110100: zero=1 -> PCSrc=01 and PCWre=1 in EXE_BR, ALUOp=001; with zero=0 -> PCSrc=00.
- jal, opcode 111010 -> 2 cycles.
  - ID has PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, PCWre=1.
- halt, opcode 111111 -> state stays 001 for 10 cycles with PCWre=0. Opcode 101010 with ILLEGAL_OP_TRAP_EN -> illegal_op=1 and hold; without it -> returns to IF after 2 cycles.
